eve_gene_aligner: RTL and testbench
===================================

# eve_gene_aligner

Upstream feeder for the EvE crossover PE. Merges two parent gene streams, each sorted by gene key, into aligned (parent1, parent2) pairs for the PE's `parent1`/`parent2`/`wr_en` inputs. Disjoint and excess genes are inherited according to which parent is fitter. While merging it also counts matching, disjoint and excess genes for the speciation compatibility stage.

## Interface
Parameters:
- GENE_W, 64, gene width; key fields are fixed positions inside the gene.
- CNT_W, 16, width of each statistic counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- start  in  1  one-cycle pulse; accepted only in IDLE.
- fit_sel  in  2  sampled at start: 01 = A fitter, 10 = B fitter, 00/11 = equal.
- a_gene, b_gene  in  GENE_W  head gene of parent A / parent B stream.
- a_valid, b_valid  in  1  head gene present.
- a_last, b_last  in  1  head gene is the last gene of its genome.
- a_ready, b_ready  out  1  head gene consumed this cycle.
- parent1, parent2  out  GENE_W  aligned pair, wired to PE `parent1`/`parent2`.
- wr_en  out  1  pair valid, wired to PE `wr_en`.
- out_ready  in  1  PE accepts pair; tied high when the PE never stalls.
- match_cnt, disjoint_cnt, excess_cnt  out  CNT_W  statistics, valid when done=1.
- done  out  1  one-cycle pulse after the final pair transfers.
- busy  out  1  high outside IDLE.
- order_err  out  1  sticky: a stream key did not strictly increase; cleared on start.

## Operation
- Key of a gene g: is_conn = g[55].
  - Node gene: key = {0, g[47:40], 8'h00}.
  - Connection gene: key = {1, g[47:40], g[39:32]}.
  - Keys are 17-bit unsigned values, so all node genes sort before all connection genes.
- FSM states:
  - IDLE: waits for start.
  - MERGE: both streams are live.
  - DRAIN_A: only A is live.
  - DRAIN_B: only B is live.
  - FLUSH: waits for the final output transfer, then pulses done and returns to IDLE.
- One decision per cycle in MERGE/DRAIN. A decision requires the needed head(s) valid and the output slot free or transferring this cycle.
- Decision rules in MERGE:
  - keyA == keyB: pop both; emit (A, B); match_cnt+1.
  - keyA < keyB: pop A; disjoint_cnt+1; emit (A, A) if A fitter or equal, else emit nothing.
  - keyB < keyA: mirror of the above; emit (B, B) if B fitter or equal.
- Leaving MERGE:
  - Pop of a gene with a_last (and not b_last) → DRAIN_B.
  - Pop with b_last (and not a_last) → DRAIN_A.
  - Both last → FLUSH.
- DRAIN_x: pop x each decision; excess_cnt+1; emit (x, x) only if x is fitter or equal. Popping x_last → FLUSH.
- A parent whose genes are dropped is still popped (ready=1) so its stream drains.
- order_err: set when a popped key ≤ the previous popped key of the same stream. Processing continues unchanged.
- Counters saturate at all-ones.
- Each stream must contain at least one gene; empty genomes are outside the contract.

## Timing
- Reset values: wr_en=0, parent1/parent2=0, a_ready/b_ready=0, done=0, busy=0, order_err=0, all counters 0, state IDLE.
- start in IDLE clears counters and order_err and enters MERGE the next cycle. start in any other state is ignored.
- Ready signals are combinational from state, heads and output-slot status.
- Latency: a pop in cycle N gives wr_en=1 with the registered pair in cycle N+1.
- Output register: holds the pair while wr_en && !out_ready. A new pair loads in the same cycle the old one transfers, so throughput is 1 pair/cycle with out_ready=1.
- A dropped gene does not occupy the output slot and may pop while a stalled pair is held.
- done pulses in the cycle after the last transfer (or after the last pop, if nothing is pending). busy falls in the same cycle.
- rst=0 mid-operation: all state returns to reset values next edge. Partial pairs are discarded and not emitted.

## Structure
- Shared package eve_pkg:
  - GENE_W.
  - Bit positions: CONN_BIT=55, SRC/ID field 47:40, DST field 39:32.
  - Key width 17.
  - fit_sel encodings.
  - FSM state enum.
  - key-extraction function, shared with the PE and the speciation stage.
- One natural sub-module: eve_pair_outreg, the one-entry valid/ready output register with hold.

## Test plan
- Identical genomes, node genes C82000F7…, C82001F7…, C80003F7…, B copies key-equal, fit_sel=01 → 3 pairs (A_i, B_i) on consecutive cycles; match=3, disjoint=0, excess=0; done once.
- A connections 0→3, 1→3, 3→5; B connections 0→3, 2→3, 3→5; fit_sel=10:
  - Pairs (0→3 A, 0→3 B), (2→3 B, 2→3 B), (3→5 A, 3→5 B).
  - 1→3 dropped.
  - match=2, disjoint=2, excess=0.
- A ends at 4→5, B has an extra 4→6; fit_sel=00 → final pair (B 4→6, B 4→6); excess=1.
- out_ready low for 3 cycles mid-merge → wr_en held high with a stable pair; no pops beyond one dropped gene; counts unchanged from the unstalled run.
- B key sequence 0→3 then 0→3 (duplicate) → order_err=1 sticky until the next start.
- rst=0 for one cycle during MERGE → wr_en=0, counters 0, IDLE. A following start with fresh streams completes normally.

Source files
------------

// File: rtl/eve_pkg.sv
// Shared definitions for the EvE gene pipeline: gene field positions,
// key extraction, fitness encodings and the aligner state enum.
package eve_pkg;

   localparam int GENE_W   = 64;
   localparam int CONN_BIT = 55;
   localparam int ID_HI    = 47;
   localparam int ID_LO    = 40;
   localparam int DST_HI   = 39;
   localparam int DST_LO   = 32;
   localparam int KEY_W    = 17;

   localparam logic [1:0] FIT_EQ   = 2'b00;
   localparam logic [1:0] FIT_A    = 2'b01;
   localparam logic [1:0] FIT_B    = 2'b10;
   localparam logic [1:0] FIT_EQ_2 = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MERGE,
      S_DRAIN_A,
      S_DRAIN_B,
      S_FLUSH
   } state_t;

   // Node genes sort before every connection gene because the conn bit is the key MSB.
   function automatic logic [KEY_W-1:0] gene_key(input logic [GENE_W-1:0] g);
      logic is_conn;
      is_conn  = g[CONN_BIT];
      gene_key = {is_conn, g[ID_HI:ID_LO], (is_conn ? g[DST_HI:DST_LO] : 8'h00)};
   endfunction

endpackage

// File: rtl/eve_pair_outreg.sv
// One-entry output register for aligned gene pairs; holds while the PE stalls.
module eve_pair_outreg #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] p1_d,
   input  logic [W-1:0] p2_d,
   input  logic         out_ready,
   output logic         wr_en,
   output logic [W-1:0] parent1,
   output logic [W-1:0] parent2,
   output logic         slot_free
);

   // A new pair may load when empty or when the current pair transfers now.
   assign slot_free = !wr_en || out_ready;

   // Pair register: load wins over drain so back-to-back pairs flow at full rate.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         parent1 <= '0;
         parent2 <= '0;
      end else if (load) begin
         wr_en   <= 1'b1;
         parent1 <= p1_d;
         parent2 <= p2_d;
      end else if (out_ready) begin
         wr_en   <= 1'b0;
      end
   end

endmodule

// File: rtl/eve_gene_aligner.sv
// Merges two key-sorted parent gene streams into aligned pairs for the
// crossover PE and counts matching / disjoint / excess genes.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for start
// S_MERGE   | both streams live, one key comparison per cycle
// S_DRAIN_A | B finished, remaining A genes are excess
// S_DRAIN_B | A finished, remaining B genes are excess
// S_FLUSH   | waiting for the last pair to leave, then done
module eve_gene_aligner #(
   parameter int GENE_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        fit_sel,
   input  logic [GENE_W-1:0] a_gene,
   input  logic [GENE_W-1:0] b_gene,
   input  logic              a_valid,
   input  logic              b_valid,
   input  logic              a_last,
   input  logic              b_last,
   output logic              a_ready,
   output logic              b_ready,
   output logic [GENE_W-1:0] parent1,
   output logic [GENE_W-1:0] parent2,
   output logic              wr_en,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [CNT_W-1:0]  disjoint_cnt,
   output logic [CNT_W-1:0]  excess_cnt,
   output logic              done,
   output logic              busy,
   output logic              order_err
);

   import eve_pkg::*;

   state_t              state_q, state_d;
   logic [1:0]          fit_q;
   logic [KEY_W-1:0]    key_a, key_b, prev_a_q, prev_b_q;
   logic                seen_a_q, seen_b_q;
   logic                keep_a, keep_b;
   logic                pop_a, pop_b, load, slot_free;
   logic [GENE_W-1:0]   p1_d, p2_d;
   logic                inc_match, inc_disj, inc_exc;
   logic                done_d, done_q;
   logic                start_ok;

   assign key_a    = gene_key(a_gene);
   assign key_b    = gene_key(b_gene);
   assign keep_a   = (fit_q != FIT_B);
   assign keep_b   = (fit_q != FIT_A);
   assign start_ok = (state_q == S_IDLE) && start;

   assign a_ready  = pop_a;
   assign b_ready  = pop_b;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

   // Decision logic: at most one merge/drain step per cycle; dropped genes bypass the output slot.
   always_comb begin
      state_d   = state_q;
      pop_a     = 1'b0;
      pop_b     = 1'b0;
      load      = 1'b0;
      p1_d      = a_gene;
      p2_d      = b_gene;
      inc_match = 1'b0;
      inc_disj  = 1'b0;
      inc_exc   = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_MERGE;
         end
         S_MERGE: begin
            if (a_valid && b_valid) begin
               if (key_a == key_b) begin
                  if (slot_free) begin
                     pop_a     = 1'b1;
                     pop_b     = 1'b1;
                     load      = 1'b1;
                     inc_match = 1'b1;
                  end
               end else if (key_a < key_b) begin
                  if (slot_free || !keep_a) begin
                     pop_a    = 1'b1;
                     inc_disj = 1'b1;
                     load     = keep_a;
                     p2_d     = a_gene;
                  end
               end else begin
                  if (slot_free || !keep_b) begin
                     pop_b    = 1'b1;
                     inc_disj = 1'b1;
                     load     = keep_b;
                     p1_d     = b_gene;
                  end
               end
               if (pop_a && a_last && pop_b && b_last) state_d = S_FLUSH;
               else if (pop_a && a_last)               state_d = S_DRAIN_B;
               else if (pop_b && b_last)               state_d = S_DRAIN_A;
            end
         end
         S_DRAIN_A: begin
            if (a_valid && (slot_free || !keep_a)) begin
               pop_a   = 1'b1;
               inc_exc = 1'b1;
               load    = keep_a;
               p2_d    = a_gene;
               if (a_last) state_d = S_FLUSH;
            end
         end
         S_DRAIN_B: begin
            if (b_valid && (slot_free || !keep_b)) begin
               pop_b   = 1'b1;
               inc_exc = 1'b1;
               load    = keep_b;
               p1_d    = b_gene;
               if (b_last) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (slot_free) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, fitness latch and done pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         fit_q   <= FIT_EQ;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (start_ok) fit_q <= fit_sel;
      end
   end

   // Saturating statistics, cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (!rst || start_ok) begin
         match_cnt    <= '0;
         disjoint_cnt <= '0;
         excess_cnt   <= '0;
      end else begin
         if (inc_match && (match_cnt != '1))    match_cnt    <= match_cnt + CNT_W'(1);
         if (inc_disj  && (disjoint_cnt != '1)) disjoint_cnt <= disjoint_cnt + CNT_W'(1);
         if (inc_exc   && (excess_cnt != '1))   excess_cnt   <= excess_cnt + CNT_W'(1);
      end
   end

   // Per-stream key history; the first gene of each genome has nothing to compare against.
   always_ff @(posedge clk) begin
      if (!rst || start_ok) begin
         order_err <= 1'b0;
         prev_a_q  <= '0;
         prev_b_q  <= '0;
         seen_a_q  <= 1'b0;
         seen_b_q  <= 1'b0;
      end else begin
         if (pop_a) begin
            if (seen_a_q && (key_a <= prev_a_q)) order_err <= 1'b1;
            prev_a_q <= key_a;
            seen_a_q <= 1'b1;
         end
         if (pop_b) begin
            if (seen_b_q && (key_b <= prev_b_q)) order_err <= 1'b1;
            prev_b_q <= key_b;
            seen_b_q <= 1'b1;
         end
      end
   end

   // Output pair register toward the PE.
   eve_pair_outreg #(.W(GENE_W)) u_outreg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .p1_d      (p1_d),
      .p2_d      (p2_d),
      .out_ready (out_ready),
      .wr_en     (wr_en),
      .parent1   (parent1),
      .parent2   (parent2),
      .slot_free (slot_free)
   );

endmodule

// File: tb/tb_eve_gene_aligner.sv
// Directed bench for eve_gene_aligner with a list-merge reference model.
module tb_eve_gene_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  fit_sel;
   logic [63:0] a_gene, b_gene;
   logic        a_valid, b_valid, a_last, b_last;
   logic        a_ready, b_ready;
   logic [63:0] parent1, parent2;
   logic        wr_en;
   logic        out_ready;
   logic [15:0] match_cnt, disjoint_cnt, excess_cnt;
   logic        done, busy, order_err;

   eve_gene_aligner #(.GENE_W(64), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .fit_sel(fit_sel),
      .a_gene(a_gene), .b_gene(b_gene), .a_valid(a_valid), .b_valid(b_valid),
      .a_last(a_last), .b_last(b_last), .a_ready(a_ready), .b_ready(b_ready),
      .parent1(parent1), .parent2(parent2), .wr_en(wr_en), .out_ready(out_ready),
      .match_cnt(match_cnt), .disjoint_cnt(disjoint_cnt), .excess_cnt(excess_cnt),
      .done(done), .busy(busy), .order_err(order_err)
   );

   always #5 clk = ~clk;

   logic [63:0]  a_mem [8];
   logic [63:0]  b_mem [8];
   int           na, nb, ia, ib;
   int           errors = 0;
   int           checks = 0;
   logic [127:0] exp_q [$];
   int           exp_match, exp_disj, exp_exc;
   logic         exp_oerr;
   bit           chk_en = 0;
   int           done_cnt;
   int           stall_pops;
   logic [63:0]  last_p1, last_p2;
   bit           prev_stall = 0;
   logic [127:0] prev_pair;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [16:0] tb_key(input logic [63:0] g);
      logic [16:0] k;
      if (g[55]) k = {1'b1, g[47:40], g[39:32]};
      else       k = {1'b0, g[47:40], 8'h00};
      return k;
   endfunction

   function automatic logic [63:0] mk_conn(input logic [7:0] src, input logic [7:0] dst,
                                          input logic [31:0] tag);
      return {8'h00, 8'h80, src, dst, tag};
   endfunction

   // Reference: plain two-list merge with fitness-based inheritance.
   task automatic build_model(input logic [1:0] fit);
      int i, j;
      bit ka_keep, kb_keep;
      i = 0; j = 0;
      ka_keep = (fit != 2'b10);
      kb_keep = (fit != 2'b01);
      exp_q.delete();
      exp_match = 0; exp_disj = 0; exp_exc = 0; exp_oerr = 1'b0;
      for (int k = 1; k < na; k++) if (tb_key(a_mem[k]) <= tb_key(a_mem[k-1])) exp_oerr = 1'b1;
      for (int k = 1; k < nb; k++) if (tb_key(b_mem[k]) <= tb_key(b_mem[k-1])) exp_oerr = 1'b1;
      while (i < na || j < nb) begin
         if (i < na && j < nb) begin
            if (tb_key(a_mem[i]) == tb_key(b_mem[j])) begin
               exp_q.push_back({a_mem[i], b_mem[j]}); exp_match++; i++; j++;
            end else if (tb_key(a_mem[i]) < tb_key(b_mem[j])) begin
               if (ka_keep) exp_q.push_back({a_mem[i], a_mem[i]});
               exp_disj++; i++;
            end else begin
               if (kb_keep) exp_q.push_back({b_mem[j], b_mem[j]});
               exp_disj++; j++;
            end
         end else if (i < na) begin
            if (ka_keep) exp_q.push_back({a_mem[i], a_mem[i]});
            exp_exc++; i++;
         end else begin
            if (kb_keep) exp_q.push_back({b_mem[j], b_mem[j]});
            exp_exc++; j++;
         end
      end
   endtask

   task automatic set_heads();
      a_valid = (ia < na);
      b_valid = (ib < nb);
      a_gene  = a_valid ? a_mem[ia] : 64'd0;
      b_gene  = b_valid ? b_mem[ib] : 64'd0;
      a_last  = (ia == na - 1);
      b_last  = (ib == nb - 1);
   endtask

   task automatic step();
      bit pa, pb;
      @(negedge clk);
      pa = a_ready;
      pb = b_ready;
      if (!out_ready && (pa || pb)) stall_pops++;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (pa) ia++;
      if (pb) ib++;
      set_heads();
   endtask

   task automatic run_test(input logic [1:0] fit, input int stall_at, input int stall_len);
      int k;
      build_model(fit);
      stall_pops = 0; done_cnt = 0; ia = 0; ib = 0;
      set_heads();
      fit_sel = fit;
      start   = 1'b1;
      chk_en  = 1;
      k = 0;
      while (done_cnt == 0 && k < 200) begin
         out_ready = !(k >= stall_at && k < stall_at + stall_len);
         step();
         k++;
      end
      if (done_cnt == 0) begin
         errors++; checks++;
         $display("FAIL done_timeout actual=no_done required=done within 200 cycles");
      end
      out_ready = 1'b1;
      repeat (3) step();
      check("done_once", 64'(done_cnt), 64'd1);
      chk_en = 0;
   endtask

   // Compare process: every transfer against the model, stall hold, and stats at done.
   always @(negedge clk) begin
      logic [127:0] e;
      if (chk_en) begin
         if (prev_stall) begin
            check("hold_wr_en", 64'(wr_en), 64'd1);
            check("hold_p1", parent1, prev_pair[127:64]);
            check("hold_p2", parent2, prev_pair[63:0]);
         end
         if (wr_en && out_ready) begin
            if (exp_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL extra_pair actual=%h/%h required=none", parent1, parent2);
            end else begin
               e = exp_q.pop_front();
               check("pair_p1", parent1, e[127:64]);
               check("pair_p2", parent2, e[63:0]);
            end
            last_p1 = parent1;
            last_p2 = parent2;
         end
         if (done) begin
            done_cnt++;
            check("match_cnt", 64'(match_cnt), 64'(exp_match));
            check("disjoint_cnt", 64'(disjoint_cnt), 64'(exp_disj));
            check("excess_cnt", 64'(excess_cnt), 64'(exp_exc));
            check("order_err", 64'(order_err), 64'(exp_oerr));
            check("busy_at_done", 64'(busy), 64'd0);
            check("pairs_left", 64'(exp_q.size()), 64'd0);
         end
      end
      prev_stall = chk_en && wr_en && !out_ready;
      prev_pair  = {parent1, parent2};
   end

   task automatic load_t1();
      na = 3; nb = 3;
      a_mem[0] = 64'hC82000F7_0000000A; b_mem[0] = 64'hC82000F7_0000000B;
      a_mem[1] = 64'hC82001F7_0000001A; b_mem[1] = 64'hC82001F7_0000001B;
      a_mem[2] = 64'hC80003F7_0000002A; b_mem[2] = 64'hC80003F7_0000002B;
   endtask

   task automatic load_t2();
      na = 3; nb = 3;
      a_mem[0] = mk_conn(8'd0, 8'd3, 32'hA0); b_mem[0] = mk_conn(8'd0, 8'd3, 32'hB0);
      a_mem[1] = mk_conn(8'd1, 8'd3, 32'hA1); b_mem[1] = mk_conn(8'd2, 8'd3, 32'hB1);
      a_mem[2] = mk_conn(8'd3, 8'd5, 32'hA2); b_mem[2] = mk_conn(8'd3, 8'd5, 32'hB2);
   endtask

   task automatic load_t3();
      na = 2; nb = 3;
      a_mem[0] = mk_conn(8'd0, 8'd3, 32'hA0); b_mem[0] = mk_conn(8'd0, 8'd3, 32'hB0);
      a_mem[1] = mk_conn(8'd4, 8'd5, 32'hA1); b_mem[1] = mk_conn(8'd4, 8'd5, 32'hB1);
      b_mem[2] = mk_conn(8'd4, 8'd6, 32'hB2);
   endtask

   task automatic load_t5();
      na = 2; nb = 2;
      a_mem[0] = mk_conn(8'd0, 8'd3, 32'hA0); b_mem[0] = mk_conn(8'd0, 8'd3, 32'hB0);
      a_mem[1] = mk_conn(8'd1, 8'd3, 32'hA1); b_mem[1] = mk_conn(8'd0, 8'd3, 32'hB1);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; fit_sel = 2'b00; out_ready = 1'b1;
      na = 0; nb = 0; ia = 0; ib = 0;
      set_heads();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_parent1", parent1, 64'd0);
      check("rst_parent2", parent2, 64'd0);
      check("rst_ready", 64'({a_ready, b_ready}), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_order_err", 64'(order_err), 64'd0);
      check("rst_counts", 64'({match_cnt, disjoint_cnt, excess_cnt}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // identical node genomes, A fitter
      load_t1();
      run_test(2'b01, 0, 0);
      check("t1_match", 64'(match_cnt), 64'd3);
      check("t1_disj", 64'(disjoint_cnt), 64'd0);
      check("t1_last_p2", last_p2, 64'hC80003F7_0000002B);

      // connection genomes, B fitter: 1->3 dropped
      load_t2();
      run_test(2'b10, 0, 0);
      check("t2_match", 64'(match_cnt), 64'd2);
      check("t2_disj", 64'(disjoint_cnt), 64'd2);
      check("t2_excess", 64'(excess_cnt), 64'd0);
      check("t2_last_p1", last_p1, mk_conn(8'd3, 8'd5, 32'hA2));

      // B has one excess gene, equal fitness
      load_t3();
      run_test(2'b00, 0, 0);
      check("t3_excess", 64'(excess_cnt), 64'd1);
      check("t3_last_p1", last_p1, mk_conn(8'd4, 8'd6, 32'hB2));
      check("t3_last_p2", last_p2, mk_conn(8'd4, 8'd6, 32'hB2));

      // same as t2 with the PE stalled for three cycles mid-merge
      load_t2();
      run_test(2'b10, 2, 3);
      check("t4_stall_pops", 64'(stall_pops), 64'd1);
      check("t4_match", 64'(match_cnt), 64'd2);
      check("t4_disj", 64'(disjoint_cnt), 64'd2);

      // duplicate key in B: sticky order error until the next start
      load_t5();
      run_test(2'b01, 0, 0);
      check("t5_order_err", 64'(order_err), 64'd1);
      check("t5_excess", 64'(excess_cnt), 64'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t5_order_err_sticky", 64'(order_err), 64'd1);
      @(posedge clk); #1;
      load_t1();
      run_test(2'b01, 0, 0);
      check("t5_order_err_cleared", 64'(order_err), 64'd0);

      // reset pulse in the middle of a merge
      load_t2();
      stall_pops = 0; ia = 0; ib = 0;
      set_heads();
      fit_sel = 2'b10; start = 1'b1; out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      check("t6_wr_en", 64'(wr_en), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_counts", 64'({match_cnt, disjoint_cnt, excess_cnt}), 64'd0);
      check("t6_ready", 64'({a_ready, b_ready}), 64'd0);
      @(posedge clk); #1;
      load_t1();
      run_test(2'b01, 0, 0);
      check("t6_restart_match", 64'(match_cnt), 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
